// File: rtl/counter_fifo_stream.sv
// Counter-to-FIFO sample stream: two-stage clock-enable divider, running counter, FWFT FIFO drained by valid/ready.
// Optional COUNTER_FIFO_DROP_CNT_EN adds a saturating 16-bit drop_count output.
module counter_fifo_stream #(
    parameter int CLK_DIV1  = 5000,
    parameter int CLK_DIV2  = 500,
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 128,
    parameter int START_VAL = 1,
    parameter int LED_W     = 8
) (
    input  logic                     clk100,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     dout_ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     data_ready,
`ifdef COUNTER_FIFO_DROP_CNT_EN
    output logic [15:0]              drop_count,
`endif
    output logic [LED_W-1:0]         led
);

    localparam int D1W = $clog2(CLK_DIV1);
    localparam int D2W = (CLK_DIV2 > 1) ? $clog2(CLK_DIV2) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam logic [D1W-1:0]   DIV1_LAST = D1W'(CLK_DIV1 - 1);
    localparam logic [D2W-1:0]   DIV2_LAST = D2W'(CLK_DIV2 - 1);
    localparam logic [AW:0]      FILL_MAX  = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] CNT_INIT  = WIDTH'(START_VAL);

    logic [D1W-1:0]   div1_q, div1_d;
    logic [D2W-1:0]   div2_q, div2_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             dr_q, dr_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic tick1, tick2, push_req, push_ok, pop, drop;

    assign dout       = empty_q ? '0 : mem[rd_ptr_q];
    assign dout_valid = !empty_q;
    assign fill_count = fill_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign overflow   = ovf_q;
    assign data_ready = dr_q;
    assign led        = led_q;

    always_comb begin
        tick1    = (div1_q == DIV1_LAST);
        tick2    = tick1 && (div2_q == DIV2_LAST);
        pop      = !empty_q && dout_ready;
        push_req = tick2 && enable;
        // A full FIFO still takes the sample if the head leaves in the same cycle.
        push_ok  = push_req && (!full_q || pop);
        drop     = push_req && !push_ok;

        div1_d = tick1 ? '0 : div1_q + D1W'(1);
        div2_d = div2_q;
        if (tick1) begin
            div2_d = tick2 ? '0 : div2_q + D2W'(1);
        end

        cnt_d    = push_req ? cnt_q + WIDTH'(1) : cnt_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        fill_d = fill_q;
        case ({push_ok, pop})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase
        full_d  = (fill_d == FILL_MAX);
        empty_d = (fill_d == '0);

        ovf_d = ovf_q || drop;
        dr_d  = tick2 ? !dr_q : dr_q;
        led_d = pop ? dout[LED_W-1:0] : led_q;
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            div1_q   <= '0;
            div2_q   <= '0;
            cnt_q    <= CNT_INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            dr_q     <= 1'b0;
            led_q    <= '0;
        end else begin
            div1_q   <= div1_d;
            div2_q   <= div2_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            dr_q     <= dr_d;
            led_q    <= led_d;
        end
    end

    // Storage needs no reset: dout is forced to 0 while empty.
    always_ff @(posedge clk100) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= cnt_q;
        end
    end

`ifdef COUNTER_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
